// File: rtl/consec_ones_sched.sv
// Round-robin scheduler sharing one consecutive-ones run detector among NUM_CH
// serial channels, with a saved run-length context per channel.
module consec_ones_sched #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int RUN_W  = 4,
  parameter int THRESH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] bit_in,
  output logic [NUM_CH-1:0] gnt,
  input  logic [NUM_CH-1:0] ch_clr,
  input  logic              cfg_we,
  input  logic [RUN_W-1:0]  cfg_thresh,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_det,
  output logic [RUN_W-1:0]  run_len,
  output logic [15:0]       det_total
);

  localparam logic [RUN_W-1:0] CNT_MAX = {RUN_W{1'b1}};

  logic [CH_W-1:0]  ptr_q;
  logic [RUN_W-1:0] thr_q;
  logic [RUN_W-1:0] cnt_q [NUM_CH];
  logic             out_valid_q;
  logic [CH_W-1:0]  out_ch_q;
  logic             out_det_q;
  logic [RUN_W-1:0] run_len_q;
  logic [15:0]      det_total_q;

  logic [NUM_CH-1:0] gnt_d;
  logic [CH_W-1:0]   cand;
  logic [CH_W-1:0]   g_idx;
  logic              consume;
  logic [RUN_W-1:0]  g_cnt;
  logic [RUN_W-1:0]  cnt_d;
  logic [RUN_W-1:0]  eff_thr;
  logic              det_d;

  // Search starts one past the last served channel, so the last winner
  // drops to lowest priority.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    gnt_d   = '0;
    cand    = '0;
    g_idx   = '0;
    consume = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
      if (!consume && req[cand]) begin
        consume = 1'b1;
        g_idx   = cand;
      end
    end
    if (consume) gnt_d[g_idx] = 1'b1;
  end

  assign gnt = gnt_d;

  // Updated context for the granted channel; a same-cycle clear wins.
  always_comb begin
    g_cnt   = cnt_q[g_idx];
    eff_thr = (thr_q == '0) ? RUN_W'(1) : thr_q;
    if (ch_clr[g_idx] || !bit_in[g_idx]) begin
      cnt_d = '0;
    end else if (g_cnt == CNT_MAX) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = g_cnt + RUN_W'(1);
    end
    det_d = consume && bit_in[g_idx] && !ch_clr[g_idx] && (cnt_d >= eff_thr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the context array is only NUM_CH small registers, so it is reset
      // with everything else; a reset loses every channel's run.
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      ptr_q       <= CH_W'(NUM_CH - 1);
      thr_q       <= RUN_W'(THRESH);
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_det_q   <= 1'b0;
      run_len_q   <= '0;
      det_total_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, e.g. a consume sees the old thr_q during cfg_we.
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i]) begin
          cnt_q[i] <= '0;
        end else if (consume && g_idx == CH_W'(i)) begin
          cnt_q[i] <= cnt_d;
        end
      end
      if (consume) ptr_q <= g_idx;
      if (cfg_we)  thr_q <= cfg_thresh;
      out_valid_q <= consume;
      out_det_q   <= det_d;
      if (consume) begin
        out_ch_q  <= g_idx;
        run_len_q <= cnt_d;
      end
      if (det_d) det_total_q <= det_total_q + 16'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_det   = out_det_q;
  assign run_len   = run_len_q;
  assign det_total = det_total_q;

endmodule

// File: tb/tb_consec_ones_sched.sv
// Bench for consec_ones_sched: directed scenarios plus a randomized run checked
// against a per-channel behavioural model of the scheduler.
module tb_consec_ones_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int RUN_W  = 4;
  localparam int THRESH = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] req, bit_in, gnt, ch_clr;
  logic              cfg_we;
  logic [RUN_W-1:0]  cfg_thresh;
  logic              out_valid, out_det;
  logic [CH_W-1:0]   out_ch;
  logic [RUN_W-1:0]  run_len;
  logic [15:0]       det_total;

  int vectors     = 0;
  int miscompares = 0;

  consec_ones_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .RUN_W(RUN_W), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .gnt(gnt),
    .ch_clr(ch_clr), .cfg_we(cfg_we), .cfg_thresh(cfg_thresh),
    .out_valid(out_valid), .out_ch(out_ch), .out_det(out_det),
    .run_len(run_len), .det_total(det_total)
  );

  always #5 clk = ~clk;

  // Reference model state and the expectations for the most recent cycle.
  int         m_cnt[NUM_CH];
  int         m_ptr, m_thr, m_total;
  logic [3:0] e_gnt, obs_gnt;
  logic       e_valid, e_det;
  int         e_ch, e_run;

  function automatic logic bit_of(input logic [3:0] v, input int i);
    return v[2'(i)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    m_ptr = NUM_CH - 1; m_thr = THRESH; m_total = 0;
  endtask

  task automatic model_step(input logic [3:0] r, b, c, input logic we, input logic [3:0] th);
    int g = -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      int cidx = (m_ptr + k) % NUM_CH;
      if (g < 0 && bit_of(r, cidx)) g = cidx;
    end
    e_gnt   = (g >= 0) ? 4'(1 << g) : 4'b0;
    e_valid = (g >= 0);
    e_det   = 1'b0;
    if (g >= 0) begin
      int nc;
      if (bit_of(c, g) || !bit_of(b, g)) nc = 0;
      else nc = (m_cnt[g] + 1 > 15) ? 15 : m_cnt[g] + 1;
      e_det   = bit_of(b, g) && !bit_of(c, g) && nc >= ((m_thr == 0) ? 1 : m_thr);
      e_ch    = g;
      e_run   = nc;
      m_total = (m_total + int'(e_det)) % 65536;
      m_ptr   = g;
      m_cnt[g] = nc;
    end
    for (int i = 0; i < NUM_CH; i++) if (bit_of(c, i)) m_cnt[i] = 0;
    if (we) m_thr = int'(th);
  endtask

  // Applies one cycle of inputs from posedge+1, samples gnt before the edge
  // and leaves the caller at posedge+1 with the registered outputs settled.
  task automatic drive_cycle(input logic [3:0] r, b, c, input logic we, input logic [3:0] th);
    req = r; bit_in = b; ch_clr = c; cfg_we = we; cfg_thresh = th;
    #1 obs_gnt = gnt;
    model_step(r, b, c, we, th);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; bit_in = '0; ch_clr = '0; cfg_we = 1'b0; cfg_thresh = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b0101; bit_in = '1; ch_clr = '0; cfg_we = 1'b0; cfg_thresh = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (gnt !== 4'b0001) begin miscompares++; $display("FAIL reset_gnt: got %b want 0001", gnt); end
    vectors++;
    if ({out_valid, out_det, out_ch, run_len, det_total} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b det=%b ch=%0d run=%0d total=%0d want all 0",
               out_valid, out_det, out_ch, run_len, det_total);
    end
    req = 4'b0100; #1;
    vectors++;
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL reset_gnt_follow: got %b want 0100", gnt); end
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_run();
    logic [3:0] bits[6] = '{4'b1, 4'b1, 4'b1, 4'b1, 4'b0, 4'b1};
    logic       det_tab[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int         run_tab[6] = '{1, 2, 3, 4, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(4'b0001, bits[i], 4'b0, 1'b0, 4'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_det !== det_tab[i] || int'(run_len) != run_tab[i]) begin
        miscompares++;
        $display("FAIL basic_run[%0d]: valid=%b det=%b run=%0d want valid=1 det=%b run=%0d",
                 i, out_valid, out_det, run_len, det_tab[i], run_tab[i]);
      end
    end
    vectors++;
    if (det_total !== 16'd2) begin miscompares++; $display("FAIL basic_total: got %0d want 2", det_total); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(4'b1111, 4'b0, 4'b0, 1'b0, 4'b0);
      vectors++;
      if (obs_gnt !== 4'(1 << (i % 4)) || out_valid !== 1'b1 || int'(out_ch) != i % 4) begin
        miscompares++;
        $display("FAIL round_robin[%0d]: gnt=%b ch=%0d valid=%b want gnt=%b ch=%0d valid=1",
                 i, obs_gnt, out_ch, out_valid, 4'(1 << (i % 4)), i % 4);
      end
    end
  endtask

  task automatic test_interleave();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic want_det = (i >= 4);
      drive_cycle(4'b0110, 4'b0110, 4'b0, 1'b0, 4'b0);
      vectors++;
      if (int'(out_ch) != 1 + (i % 2) || out_det !== want_det || int'(run_len) != 1 + i / 2) begin
        miscompares++;
        $display("FAIL interleave[%0d]: ch=%0d det=%b run=%0d want ch=%0d det=%b run=%0d",
                 i, out_ch, out_det, run_len, 1 + (i % 2), want_det, 1 + i / 2);
      end
    end
  endtask

  task automatic test_cfg_write();
    do_reset();
    drive_cycle(4'b0001, 4'b0001, 4'b0, 1'b1, 4'd0);
    vectors++;
    if (out_det !== 1'b0 || run_len !== 4'd1) begin
      miscompares++; $display("FAIL cfg_old_thr: det=%b run=%0d want det=0 run=1", out_det, run_len);
    end
    drive_cycle(4'b0001, 4'b0001, 4'b0, 1'b0, 4'd0);
    vectors++;
    if (out_det !== 1'b1 || run_len !== 4'd2 || det_total !== 16'd1) begin
      miscompares++;
      $display("FAIL cfg_new_thr: det=%b run=%0d total=%0d want det=1 run=2 total=1", out_det, run_len, det_total);
    end
  endtask

  task automatic test_clear();
    do_reset();
    repeat (2) drive_cycle(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0);
    drive_cycle(4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_det !== 1'b0 || run_len !== 4'd0) begin
      miscompares++;
      $display("FAIL clear_wins: valid=%b det=%b run=%0d want valid=1 det=0 run=0", out_valid, out_det, run_len);
    end
    for (int i = 1; i <= 2; i++) begin
      drive_cycle(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0);
      vectors++;
      if (int'(run_len) != i || out_det !== 1'b0) begin
        miscompares++; $display("FAIL clear_restart[%0d]: run=%0d det=%b want run=%0d det=0", i, run_len, out_det, i);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive_cycle(4'b0, 4'b0, 4'b0, 1'b1, 4'd15);
    for (int i = 1; i <= 18; i++) begin
      int want_run = (i > 15) ? 15 : i;
      drive_cycle(4'b0001, 4'b0001, 4'b0, 1'b0, 4'b0);
      vectors++;
      if (int'(run_len) != want_run || out_det !== 1'(want_run >= 15)) begin
        miscompares++;
        $display("FAIL saturation[%0d]: run=%0d det=%b want run=%0d det=%b", i, run_len, out_det, want_run, want_run >= 15);
      end
    end
    vectors++;
    if (det_total !== 16'd4) begin miscompares++; $display("FAIL sat_total: got %0d want 4", det_total); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) drive_cycle(4'b1000, 4'b1000, 4'b0, 1'b0, 4'b0);
    vectors++;
    if (run_len !== 4'd2 || out_ch !== 2'd3) begin
      miscompares++; $display("FAIL mid_pre: run=%0d ch=%0d want run=2 ch=3", run_len, out_ch);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_det, out_ch, run_len, det_total} !== '0 || gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL mid_async: valid=%b det=%b ch=%0d run=%0d total=%0d gnt=%b want zeros gnt=1000",
               out_valid, out_det, out_ch, run_len, det_total, gnt);
    end
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    drive_cycle(4'b1111, 4'b0, 4'b0, 1'b0, 4'b0);
    vectors++;
    if (obs_gnt !== 4'b0001) begin miscompares++; $display("FAIL mid_first_gnt: got %b want 0001", obs_gnt); end
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(4'b1000, 4'b1000, 4'b0, 1'b0, 4'b0);
      vectors++;
      if (int'(run_len) != i || out_det !== 1'(i == 3)) begin
        miscompares++; $display("FAIL mid_restart[%0d]: run=%0d det=%b want run=%0d det=%b", i, run_len, out_det, i, i == 3);
      end
    end
  endtask

  function automatic logic [3:0] rand_bits(input int pct);
    logic [3:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v = (v << 1) | 4'($urandom_range(0, 99) < pct);
    return v;
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic       we = ($urandom_range(0, 99) < 5);
      logic [3:0] th = 4'($urandom_range(0, 6));
      drive_cycle(rand_bits(50), rand_bits(85), rand_bits(3), we, th);
      vectors++;
      if (obs_gnt !== e_gnt || out_valid !== e_valid || out_det !== e_det || det_total !== 16'(m_total)) begin
        miscompares++;
        $display("FAIL random[%0d]: gnt=%b valid=%b det=%b total=%0d want gnt=%b valid=%b det=%b total=%0d",
                 n, obs_gnt, out_valid, out_det, det_total, e_gnt, e_valid, e_det, m_total);
      end
      if (e_valid) begin
        vectors++;
        if (int'(out_ch) != e_ch || int'(run_len) != e_run) begin
          miscompares++;
          $display("FAIL random_ctx[%0d]: ch=%0d run=%0d want ch=%0d run=%0d", n, out_ch, run_len, e_ch, e_run);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_round_robin();
    test_interleave();
    test_cfg_write();
    test_clear();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
